// File: rtl/fsm_seq_sched.sv
// Round-robin scheduler sharing one six-phase sequence engine between N requesters.
// Optional FSM_SEQ_SCHED_LOCK_EN adds a lock input that chains runs for the current owner.
module fsm_seq_sched #(
  parameter  int N  = 4,
  localparam int NW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mode,
`ifdef FSM_SEQ_SCHED_LOCK_EN
  input  logic [N-1:0]  lock,
`endif
  output logic [N-1:0]  gnt,
  output logic [NW-1:0] owner,
  output logic          busy,
  output logic [3:0]    phase,
  output logic [3:0]    out,
  output logic          done,
  output logic          aborted
);

  // State encoding doubles as the externally visible phase code.
  typedef enum logic [3:0] {
    S_IDLE = 4'd8,
    S_P2   = 4'd1,
    S_P3   = 4'd3,
    S_P4   = 4'd4,
    S_P5   = 4'd5,
    S_P6   = 4'd7
  } state_t;

  localparam logic [3:0] OUT_LONG  = 4'd10;
  localparam logic [3:0] OUT_SHORT = 4'd5;

  state_t          state, state_nx;
  logic [N-1:0]    gnt_nx;
  logic [NW-1:0]   owner_nx;
  logic [3:0]      out_nx;
  logic            done_nx, aborted_nx;
  logic            mode_q, mode_nx;
  logic [NW-1:0]   win;
  logic            any_req;
  logic            restart;

  // Rotating-priority search starting just after the last owner.
  always_comb begin
    logic [NW-1:0] cand;
    cand    = '0;
    win     = owner;
    any_req = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = NW'((int'(owner) + i) % N);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

`ifdef FSM_SEQ_SCHED_LOCK_EN
  assign restart = lock[owner];
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    owner_nx   = owner;
    out_nx     = out;
    mode_nx    = mode_q;
    done_nx    = 1'b0;
    aborted_nx = 1'b0;
    if (state == S_IDLE) begin
      if (any_req) begin
        gnt_nx   = {{(N-1){1'b0}}, 1'b1} << win;
        owner_nx = win;
        mode_nx  = mode[win];
        state_nx = mode[win] ? S_P2 : S_P4;
        out_nx   = mode[win] ? OUT_LONG : OUT_SHORT;
      end
    end else if (!req[owner]) begin
      // A dropped request wins over everything, including completion in P6.
      state_nx   = S_IDLE;
      gnt_nx     = '0;
      out_nx     = '0;
      aborted_nx = 1'b1;
    end else begin
      unique case (state)
        S_P2:    state_nx = S_P3;
        S_P3:    state_nx = S_P4;
        S_P4:    state_nx = S_P5;
        S_P5:    state_nx = S_P6;
        S_P6: begin
          done_nx = 1'b1;
          if (restart) begin
            mode_nx  = mode[owner];
            state_nx = mode[owner] ? S_P2 : S_P4;
            out_nx   = mode[owner] ? OUT_LONG : OUT_SHORT;
          end else begin
            state_nx = S_IDLE;
            gnt_nx   = '0;
            out_nx   = '0;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= S_IDLE;
      gnt     <= '0;
      owner   <= NW'(N - 1);
      out     <= '0;
      mode_q  <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_nx;
      gnt     <= gnt_nx;
      owner   <= owner_nx;
      out     <= out_nx;
      mode_q  <= mode_nx;
      done    <= done_nx;
      aborted <= aborted_nx;
    end
  end

  assign busy  = (state != S_IDLE);
  assign phase = state;

endmodule

// File: tb/tb_fsm_seq_sched.sv
// Bench for fsm_seq_sched: directed scenarios followed by random traffic against a run-level model.
module tb_fsm_seq_sched;
  localparam int N  = 4;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          rstb;
  logic [N-1:0]  req, mode, lk_v;
  logic [N-1:0]  gnt;
  logic [NW-1:0] owner;
  logic          busy, done, aborted;
  logic [3:0]    phase, out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fsm_seq_sched #(.N(N)) dut (
    .clk(clk), .rstb(rstb), .req(req), .mode(mode),
`ifdef FSM_SEQ_SCHED_LOCK_EN
    .lock(lk_v),
`endif
    .gnt(gnt), .owner(owner), .busy(busy), .phase(phase), .out(out),
    .done(done), .aborted(aborted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input int g, input int ph, input int o,
                         input int d, input int a);
    chk({tag, ".gnt"},     32'(gnt),     32'(g));
    chk({tag, ".phase"},   32'(phase),   32'(ph));
    chk({tag, ".out"},     32'(out),     32'(o));
    chk({tag, ".busy"},    32'(busy),    32'(ph != 8));
    chk({tag, ".done"},    32'(done),    32'(d));
    chk({tag, ".aborted"}, 32'(aborted), 32'(a));
  endtask

  // Run-level reference: which requester owns the engine and how far through its run it is.
  int long_seq[5]  = '{1, 3, 4, 5, 7};
  int short_seq[3] = '{4, 5, 7};
  bit m_busy, m_long, m_done, m_ab;
  int m_owner, m_pos;

  function automatic void model_reset();
    m_busy = 0; m_long = 0; m_done = 0; m_ab = 0; m_owner = N - 1; m_pos = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] m,
                                     input logic [N-1:0] lk);
    int len;
    m_done = 0;
    m_ab   = 0;
    len    = m_long ? 5 : 3;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_owner + k) % N;
        if (!m_busy && r[c]) begin
          m_busy = 1; m_owner = c; m_long = m[c]; m_pos = 0;
        end
      end
    end else if (!r[m_owner]) begin
      m_busy = 0;
      m_ab   = 1;
    end else if (m_pos == len - 1) begin
      m_done = 1;
      if (lk[m_owner]) begin
        m_long = m[m_owner];
        m_pos  = 0;
      end else begin
        m_busy = 0;
      end
    end else begin
      m_pos++;
    end
  endfunction

  task automatic chk_model(input string tag);
    int eg, eph, eo;
    eg  = m_busy ? (1 << m_owner) : 0;
    eph = !m_busy ? 8 : (m_long ? long_seq[m_pos] : short_seq[m_pos]);
    eo  = !m_busy ? 0 : (m_long ? 10 : 5);
    chk_out(tag, eg, eph, eo, m_done, m_ab);
    chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
  endtask

  initial begin
    rstb = 1'b0; req = '0; mode = '0; lk_v = '0;
    @(negedge clk);
    tick; tick;
    chk_out("reset", 0, 8, 0, 0, 0);
    chk("reset.owner", 32'(owner), 32'(N - 1));
    rstb = 1'b1;
    tick;
    chk_out("idle_noreq", 0, 8, 0, 0, 0);

    // Short run on requester 0
    req = 4'b0001; mode = 4'b0000;
    tick; chk_out("short.p4", 1, 4, 5, 0, 0);
    chk("short.owner", 32'(owner), 32'd0);
    tick; chk_out("short.p5", 1, 5, 5, 0, 0);
    tick; chk_out("short.p6", 1, 7, 5, 0, 0);
    tick; chk_out("short.end", 0, 8, 0, 1, 0);
    req = '0;
    tick; chk_out("short.idle", 0, 8, 0, 0, 0);

    // Long run on requester 1
    req = 4'b0010; mode = 4'b0010;
    tick; chk_out("long.p2", 2, 1, 10, 0, 0);
    tick; chk_out("long.p3", 2, 3, 10, 0, 0);
    tick; chk_out("long.p4", 2, 4, 10, 0, 0);
    tick; chk_out("long.p5", 2, 5, 10, 0, 0);
    tick; chk_out("long.p6", 2, 7, 10, 0, 0);
    tick; chk_out("long.end", 0, 8, 0, 1, 0);
    chk("long.owner", 32'(owner), 32'd1);
    req = '0;
    tick;

    // Round robin with all requesters held
    rstb = 1'b0; #1; rstb = 1'b1;
    req = 4'b1111; mode = 4'b0000;
    for (int r = 0; r < 5; r++) begin
      tick; chk_out($sformatf("rr%0d.grant", r), 1 << (r % 4), 4, 5, 0, 0);
      chk($sformatf("rr%0d.owner", r), 32'(owner), 32'(r % 4));
      tick; tick;
      tick; chk_out($sformatf("rr%0d.end", r), 0, 8, 0, 1, 0);
    end
    req = '0;
    tick;

    // Abort of a long run on requester 2 while requester 3 waits
    req = 4'b1100; mode = 4'b0100;
    tick; chk_out("abort.p2", 4, 1, 10, 0, 0);
    tick; chk_out("abort.p3", 4, 3, 10, 0, 0);
    req = 4'b1000;
    tick; chk_out("abort.idle", 0, 8, 0, 0, 1);
    tick; chk_out("abort.next", 8, 4, 5, 0, 0);
    chk("abort.owner", 32'(owner), 32'd3);
    tick; chk_out("abort.p5", 8, 5, 5, 0, 0);

    // Asynchronous reset in P5
    rstb = 1'b0;
    #1 chk_out("areset.now", 0, 8, 0, 0, 0);
    chk("areset.owner", 32'(owner), 32'(N - 1));
    req = '0;
    tick; chk_out("areset.hold", 0, 8, 0, 0, 0);
    rstb = 1'b1;
    tick;

`ifdef FSM_SEQ_SCHED_LOCK_EN
    req = 4'b0001; mode = 4'b0000; lk_v = 4'b0001;
    tick; chk_out("lock.p4a", 1, 4, 5, 0, 0);
    tick; tick; chk_out("lock.p6a", 1, 7, 5, 0, 0);
    tick; chk_out("lock.p4b", 1, 4, 5, 1, 0);
    tick; tick;
    lk_v = '0;
    tick; chk_out("lock.end", 0, 8, 0, 1, 0);
    req = '0;
    tick;
`endif

    // Random traffic against the model
    rstb = 1'b0; req = '0; lk_v = '0;
    model_reset();
    tick;
    rstb = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      chk_model($sformatf("rnd%0d", c));
      for (int b = 0; b < N; b++)
        if ($urandom_range(9) == 0) req[b] = ~req[b];
      mode = N'($urandom);
`ifdef FSM_SEQ_SCHED_LOCK_EN
      lk_v = ($urandom_range(2) == 0) ? N'($urandom) : '0;
`endif
      @(posedge clk);
      model_step(req, mode, lk_v);
      @(negedge clk);
    end
    chk_model("rnd.final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_seq_sched.md
Name: fsm_seq_sched

Overview:
- Round-robin scheduler that shares one 6-phase sequence engine between N requesters.
- Each granted requester gets one full sequence run.
  - Long path when its mode bit is 1: phases P2..P6.
  - Short path when its mode bit is 0: phases P4..P6.
- Sits between request sources and the sequence datapath. Drives phase code, output code, grant and completion/abort flags.

Parameters:
- N, 4, number of requesters (2..8).
- NW, $clog2(N), owner index width (derived; do not override).

Ports:
- clk  input  1  clock, all state on rising edge.
- rstb  input  1  reset, asynchronous, active-low.
- req  input  N  per-requester request level; held high until done or abort.
- mode  input  N  per-requester path select, sampled only at grant (1 = long, 0 = short).
- gnt  output  N  one-hot grant, registered; all zeros in IDLE.
- owner  output  NW  index of current or last grantee.
- busy  output  1  high in any state other than IDLE.
- phase  output  4  state code: IDLE=8, P2=1, P3=3, P4=4, P5=5, P6=7.
- out  output  4  run code: 10 for a long run, 5 for a short run, 0 in IDLE.
- done  output  1  one-cycle pulse, registered, on completed run.
- aborted  output  1  one-cycle pulse, registered, on dropped request.

Behaviour:
- Reset (rstb low, async):
  - state=IDLE, gnt=0, owner=N-1 (so requester 0 wins first), out=0.
  - done=0, aborted=0, captured mode=0.
  - Reset mid-run terminates immediately, with no done or aborted pulse.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: winner = first set bit searching owner+1, owner+2, ... modulo N.
  - Next cycle: gnt=onehot(winner), owner=winner, mode captured.
  - Long (mode=1): state=P2, out=10. Short (mode=0): state=P4, out=5.
  - Latency from req seen in IDLE to grant: 1 cycle.
- Run transitions: P2->P3->P4->P5->P6->IDLE, one cycle each, unconditional.
  - Long run: 5 busy cycles. Short run: 3 busy cycles.
- done: asserted in the cycle after P6, coincident with IDLE entry and gnt clearing.
- Abort: if req[owner]==0 in any run state (P2..P6), next state=IDLE, gnt=0, out=0, aborted=1 for one cycle, no done.
  - An abort sampled in P6 takes precedence over done.
- After every run or abort, at least one IDLE cycle occurs before the next grant.
  - Minimum spacing: 4 cycles between short-run grants, 6 cycles between long-run grants.
- Requests from non-owners during a run are ignored and not queued. They are re-evaluated in IDLE.
- mode changes during a run have no effect.
- Single requester held high: re-granted repeatedly, owner unchanged.
- gnt and owner are never X after reset. gnt is always one-hot or zero.

Optional Feature:
- Macro: FSM_SEQ_SCHED_LOCK_EN.
- Defined:
  - Adds port lock (input, N).
  - If lock[owner]==1 and req[owner]==1 in P6, the next state restarts the run directly (P2 or P4 per freshly sampled mode[owner]). No IDLE cycle, no arbitration, gnt held.
  - done still pulses each completed run.
  - lock is ignored in IDLE.
- Undefined: no lock port; every run returns to IDLE and re-arbitrates.

Test Plan:
- Reset: rstb low 2 cycles -> gnt=0, phase=8, out=0, busy=0, done=0. Release, req=0 -> stays IDLE.
- Short run: req=0001, mode=0 ->
  - Next cycle gnt=0001, phase 4,5,7, out=5 for 3 cycles.
  - Then phase=8, done=1 for one cycle, gnt=0.
- Long run: req=0010, mode=0010 ->
  - phase sequence 1,3,4,5,7, out=10.
  - done after 5 busy cycles, owner=1.
- Round-robin: req=1111 held, mode=0 -> grant order 0,1,2,3,0, with one IDLE cycle between runs.
- Abort: long run on requester 2, drop req[2] during P3 ->
  - Next cycle IDLE, aborted=1, done=0.
  - Pending req[3] granted in the following arbitration.
- Async reset mid-run: pull rstb low in P5 -> immediately phase=8, gnt=0, no done. With LOCK_EN: lock=0001, req=0001 -> back-to-back runs without IDLE, done each run.
